// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic frame controller for a 12-bit AD7476-style SPI ADC.
// Each frame is CS-framed with SCLK idling high. The frame carries 4 leading
// zeros followed by 12 data bits, MSB first.
// Ports:
//   clk_i, reset_i       system clock and synchronous active-high reset
//   enable_i             run enable for the sample timer
//   adc_sdo_i            ADC serial data, asynchronous to clk_i (synchronized here)
//   adc_cs_n_o           ADC chip select, active low
//   adc_sclk_o           ADC serial clock, idles high
//   signal_o             last accepted sample (mid-scale after reset)
//   valid_o              one-clock strobe: new sample on signal_o
//   busy_o               high while a frame is in progress
//   frame_error_o        one-clock strobe: leading bits were not zero, sample dropped
//   overrun_o            one-clock strobe: timer tick arrived mid-frame and was dropped
module adc_spi_sampler #(
  parameter int SIGNAL_RESOLUTION = 12,
  parameter int MSB               = SIGNAL_RESOLUTION - 1,
  parameter int LEADING_BITS      = 4,
  parameter int FRAME_BITS        = SIGNAL_RESOLUTION + LEADING_BITS,
  parameter int CLK_DIV           = 4,
  parameter int CS_SETUP          = 2,
  parameter int SAMPLE_PERIOD     = 2000
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         adc_sdo_i,
  output logic         adc_cs_n_o,
  output logic         adc_sclk_o,
  output logic [MSB:0] signal_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         frame_error_o,
  output logic         overrun_o
);

  // Counter widths. The divider counter is shared by the CS setup interval
  // and the SCLK half-periods, so it must hold the larger of the two.
  localparam int TW      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_MAX = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int DW      = $clog2(DIV_MAX + 1);
  localparam int BW      = $clog2(FRAME_BITS + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] SETUP_LAST = DW'(CS_SETUP - 1);
  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  // Value presented on signal_o after reset; matches the downstream filter preload.
  localparam logic [MSB:0] MID_SCALE = {1'b1, {MSB{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q;
  logic                  tick;
  logic                  sdo_meta_q, sdo_sync_q;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic [MSB:0]          signal_q, signal_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the ADC data line. Every bit captured into the
  // shift register comes from sdo_sync_q.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sdo_meta_q <= 1'b0;
      sdo_sync_q <= 1'b0;
    end else begin
      sdo_meta_q <= adc_sdo_i;
      sdo_sync_q <= sdo_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Sample timer. It is held at zero while disabled, so the first tick lands
  // exactly SAMPLE_PERIOD cycles after enable_i rises. The tick is qualified
  // with enable_i so that a disable on the terminal cycle drops that tick.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer_q <= '0;
    end else if (!enable_i) begin
      timer_q <= '0;
    end else if (timer_q == TIMER_LAST) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  assign tick = enable_i && (timer_q == TIMER_LAST);

  // --------------------------------------------------------------------------
  // Frame FSM state and output registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      signal_q <= MID_SCALE;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      signal_q <= signal_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic.
  // Frame timeline, counted in clocks from the CS fall (edge 0):
  //   SETUP : edges 1..CS_SETUP. SCLK falls for bit 0 on edge CS_SETUP.
  //   SHIFT : each bit spends CLK_DIV clocks low, then CLK_DIV clocks high.
  //           Data is captured on the edge that raises SCLK, so the ADC has
  //           had a full low half-period (minus synchronizer delay) to settle.
  //   DONE  : entered when the final high half-period ends. The strobe and
  //           CS rise are issued one clock later.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    signal_d = signal_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    // A tick can only start a frame from IDLE. In any other state it is
    // reported and discarded rather than queued.
    ovr_d    = tick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          div_d   = '0;
        end
      end

      SETUP: begin
        if (div_q == SETUP_LAST) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      SHIFT: begin
        if (div_q == HALF_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            // End of the low half-period: raise SCLK and capture the bit.
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], sdo_sync_q};
          end else if (bit_q == BIT_LAST) begin
            // Last high half-period is complete. SCLK stays high.
            state_d = DONE;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        // Nonzero leading bits indicate a corrupted frame. Keep the old sample
        // so the filter never sees a garbage value.
        if (shreg_q[FRAME_BITS-1 -: LEADING_BITS] == '0) begin
          signal_d = shreg_q[MSB:0];
          valid_d  = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign adc_cs_n_o    = cs_n_q;
  assign adc_sclk_o    = sclk_q;
  assign signal_o      = signal_q;
  assign valid_o       = valid_q;
  assign busy_o        = busy_q;
  assign frame_error_o = ferr_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Testbench for adc_spi_sampler.
// Two ADC behavioural models drive the design. A higher-level reference
// (frame rule and tick/overrun arithmetic) predicts every expected value.
module tb_adc_spi_sampler;

  localparam int CLK_DIV    = 4;
  localparam int CS_SETUP   = 2;
  localparam int NBITS      = 16;
  localparam int PERIOD     = 2000;
  localparam int PERIOD2    = 100;
  localparam int FRAME_CLKS = CS_SETUP + 2 * CLK_DIV * NBITS + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default build
  logic        reset = 1'b1, enable = 1'b0, sdo = 1'b1;
  logic        cs_n, sclk, valid, busy, ferr, ovr;
  logic [11:0] signal;

  // DUT 2: short sample period, used to provoke overruns
  logic        reset2 = 1'b1, enable2 = 1'b0, sdo2 = 1'b1;
  logic        cs_n2, sclk2, valid2, busy2, ferr2, ovr2;
  logic [11:0] signal2;

  adc_spi_sampler u_dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .adc_sdo_i(sdo),
    .adc_cs_n_o(cs_n), .adc_sclk_o(sclk), .signal_o(signal), .valid_o(valid),
    .busy_o(busy), .frame_error_o(ferr), .overrun_o(ovr)
  );

  adc_spi_sampler #(.SAMPLE_PERIOD(PERIOD2)) u_dut2 (
    .clk_i(clk), .reset_i(reset2), .enable_i(enable2), .adc_sdo_i(sdo2),
    .adc_cs_n_o(cs_n2), .adc_sclk_o(sclk2), .signal_o(signal2), .valid_o(valid2),
    .busy_o(busy2), .frame_error_o(ferr2), .overrun_o(ovr2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // ADC models: each SCLK fall inside CS shifts out the next word bit, MSB first.
  logic [15:0] adc_word  = 16'h0000;
  logic [15:0] adc_word2 = 16'h0000;
  int bit_k  = 0;
  int bit_k2 = 0;
  always @(negedge cs_n)  bit_k = 0;
  always @(posedge cs_n)  sdo = 1'b1;
  always @(negedge sclk)  if (cs_n === 1'b0) begin
    sdo = (bit_k < NBITS) ? adc_word[15 - bit_k] : 1'b1;
    bit_k++;
  end
  always @(negedge cs_n2) bit_k2 = 0;
  always @(posedge cs_n2) sdo2 = 1'b1;
  always @(negedge sclk2) if (cs_n2 === 1'b0) begin
    sdo2 = (bit_k2 < NBITS) ? adc_word2[15 - bit_k2] : 1'b1;
    bit_k2++;
  end

  // Bus monitor for DUT 1 (samples on the falling clock edge)
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
  int cs_fall_cnt = 0, last_cs_fall = 0, cs_spacing = 0, cs_low_len = 0;
  int sclk_falls = 0, valid_cnt = 0, consec_valid = 0;
  always @(negedge clk) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      cs_spacing   = cyc - last_cs_fall;
      last_cs_fall = cyc;
      cs_fall_cnt++;
      sclk_falls   = 0;
    end
    if (prev_cs === 1'b0 && cs_n === 1'b1) cs_low_len = cyc - last_cs_fall;
    if (prev_sclk === 1'b1 && sclk === 1'b0 && cs_n === 1'b0) sclk_falls++;
    if (valid === 1'b1) valid_cnt++;
    if (valid === 1'b1 && prev_valid === 1'b1) consec_valid++;
    prev_cs    = cs_n;
    prev_sclk  = sclk;
    prev_valid = valid;
  end

  // Reference model state: the value signal_o must hold
  logic [11:0] ref_signal = 12'h800;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a valid/frame_error strobe; ok=0 if the bound expires.
  task automatic wait_strobe(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      step();
      if (valid === 1'b1 || ferr === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_cs_fall(input int max_cyc, output bit ok);
    int n0;
    n0 = cs_fall_cnt;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      step();
      if (cs_fall_cnt != n0) ok = 1'b1;
    end
  endtask

  // Loads the ADC word, then collects the outcome of the next frame.
  task automatic run_frame(input logic [15:0] w, output bit ok, output logic v,
                           output logic e, output logic [11:0] s, output int lat);
    adc_word = w;
    wait_strobe(PERIOD + 600, ok);
    v   = valid;
    e   = ferr;
    s   = signal;
    lat = cyc - last_cs_fall;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0;
    repeat (3) step();
    total++; if (cs_n !== 1'b1)       begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (sclk !== 1'b1)       begin bad++; $display("FAIL reset_sclk got=%b want=1", sclk); end
    total++; if (signal !== 12'h800)  begin bad++; $display("FAIL reset_signal got=%h want=800", signal); end
    total++; if (valid !== 1'b0)      begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ferr !== 1'b0)       begin bad++; $display("FAIL reset_ferr got=%b want=0", ferr); end
    total++; if (ovr !== 1'b0)        begin bad++; $display("FAIL reset_ovr got=%b want=0", ovr); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    bit ok; logic v, e; logic [11:0] s; int lat, en_cyc;
    enable = 1'b1;
    en_cyc = cyc;
    run_frame(16'h0ABC, ok, v, e, s, lat);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout no strobe"); end
    total++; if (last_cs_fall - en_cyc !== PERIOD) begin bad++; $display("FAIL single_first_tick got=%0d want=%0d", last_cs_fall - en_cyc, PERIOD); end
    total++; if (v !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL single_strobe valid=%b ferr=%b want 1/0", v, e); end
    total++; if (s !== 12'hABC) begin bad++; $display("FAIL single_signal got=%h want=abc", s); end
    total++; if (lat !== FRAME_CLKS) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, FRAME_CLKS); end
    total++; if (sclk_falls !== NBITS) begin bad++; $display("FAIL single_sclk_falls got=%0d want=%0d", sclk_falls, NBITS); end
    ref_signal = 12'hABC;
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_valid_width got=%b want=0", valid); end
    total++; if (cs_low_len !== FRAME_CLKS) begin bad++; $display("FAIL single_cs_low got=%0d want=%0d", cs_low_len, FRAME_CLKS); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [6];
    bit ok; logic v, e; logic [11:0] s; int lat;
    words[0] = 16'h0000; words[1] = 16'h0FFF; words[2] = 16'h0800;
    for (int i = 3; i < 6; i++) words[i] = 16'($urandom_range(0, 4095));
    for (int i = 0; i < 6; i++) begin
      run_frame(words[i], ok, v, e, s, lat);
      // A frame with zero leading bits must be accepted verbatim.
      if (words[i][15:12] == 4'h0) ref_signal = words[i][11:0];
      total++; if (!ok || v !== 1'b1 || s !== ref_signal)
        begin bad++; $display("FAIL b2b_sample[%0d] ok=%b valid=%b got=%h want=%h", i, ok, v, s, ref_signal); end
      total++; if (cs_spacing !== PERIOD)
        begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, cs_spacing, PERIOD); end
    end
  endtask

  task automatic test_frame_error();
    logic [15:0] w;
    bit ok; logic v, e; logic [11:0] s; int lat;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) w = 16'h8123;
      else begin
        w = 16'($urandom);
        if (w[15:12] == 4'h0) w[14] = 1'b1;
      end
      run_frame(w, ok, v, e, s, lat);
      total++; if (!ok || e !== 1'b1 || v !== 1'b0)
        begin bad++; $display("FAIL ferr_strobe[%0d] ok=%b ferr=%b valid=%b want 1/1/0", i, ok, e, v); end
      total++; if (s !== ref_signal)
        begin bad++; $display("FAIL ferr_hold[%0d] got=%h want=%h", i, s, ref_signal); end
    end
    step();
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL ferr_width got=%b want=0", ferr); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int n0, en_cyc;
    logic [15:0] w;
    adc_word = 16'h0555;
    wait_cs_fall(PERIOD + 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_cs_timeout"); end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (sclk_falls >= 8) ok = 1'b1;
    end
    total++; if (!ok || busy !== 1'b1) begin bad++; $display("FAIL midrst_busy ok=%b busy=%b want 1", ok, busy); end
    reset = 1'b1; enable = 1'b0;
    step();
    ref_signal = 12'h800;
    total++; if (cs_n !== 1'b1 || sclk !== 1'b1)
      begin bad++; $display("FAIL midrst_lines cs_n=%b sclk=%b want 1/1", cs_n, sclk); end
    total++; if (signal !== 12'h800) begin bad++; $display("FAIL midrst_signal got=%h want=800", signal); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_clr got=%b want=0", busy); end
    reset = 1'b0;
    n0 = cs_fall_cnt;
    repeat (500) step();
    total++; if (cs_fall_cnt !== n0) begin bad++; $display("FAIL midrst_idle falls=%0d want=%0d", cs_fall_cnt, n0); end
    w = 16'($urandom_range(0, 4095));
    adc_word = w;
    enable = 1'b1;
    en_cyc = cyc;
    wait_cs_fall(PERIOD + 200, ok);
    total++; if (!ok || last_cs_fall - en_cyc !== PERIOD)
      begin bad++; $display("FAIL midrst_restart ok=%b delay=%0d want=%0d", ok, last_cs_fall - en_cyc, PERIOD); end
    wait_strobe(400, ok);
    ref_signal = w[11:0];
    total++; if (!ok || valid !== 1'b1 || signal !== ref_signal)
      begin bad++; $display("FAIL midrst_sample ok=%b got=%h want=%h", ok, signal, ref_signal); end
  endtask

  task automatic test_enable_drop();
    bit ok; int vc0, n0;
    logic [15:0] w;
    w = 16'($urandom_range(0, 4095));
    adc_word = w;
    wait_cs_fall(PERIOD + 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL endrop_cs_timeout"); end
    vc0 = valid_cnt;
    repeat (10) step();
    enable = 1'b0;
    wait_strobe(400, ok);
    ref_signal = w[11:0];
    total++; if (!ok || valid !== 1'b1 || signal !== ref_signal)
      begin bad++; $display("FAIL endrop_sample ok=%b got=%h want=%h", ok, signal, ref_signal); end
    n0 = cs_fall_cnt;
    repeat (10000) step();
    total++; if (valid_cnt - vc0 !== 1) begin bad++; $display("FAIL endrop_valid_count got=%0d want=1", valid_cnt - vc0); end
    total++; if (cs_fall_cnt !== n0) begin bad++; $display("FAIL endrop_quiet falls=%0d want=%0d", cs_fall_cnt - n0, 0); end
  endtask

  task automatic test_overrun();
    int exp_frames, exp_ovr, free_at, t;
    int got_valid, got_ovr, got_ferr, bad_val, consec2;
    logic pv;
    logic [15:0] w;
    // Ticks land every PERIOD2 clocks after enable; a tick starts a frame only
    // if the previous frame has fully returned to idle, otherwise it overruns.
    exp_frames = 0; exp_ovr = 0; free_at = -1;
    for (int k = 1; k <= 10; k++) begin
      t = k * PERIOD2;
      if (t > free_at) begin exp_frames++; free_at = t + FRAME_CLKS; end
      else exp_ovr++;
    end
    w = 16'($urandom_range(0, 4095));
    adc_word2 = w;
    reset2 = 1'b0;
    step();
    enable2 = 1'b1;
    got_valid = 0; got_ovr = 0; got_ferr = 0; bad_val = 0; consec2 = 0; pv = 1'b0;
    for (int i = 0; i < 10 * PERIOD2 + 50; i++) begin
      step();
      if (valid2 === 1'b1) begin
        got_valid++;
        if (signal2 !== w[11:0]) bad_val++;
        if (pv) consec2++;
      end
      if (ovr2 === 1'b1) got_ovr++;
      if (ferr2 === 1'b1) got_ferr++;
      pv = (valid2 === 1'b1);
    end
    enable2 = 1'b0;
    total++; if (got_ovr !== exp_ovr) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", got_ovr, exp_ovr); end
    total++; if (got_valid !== exp_frames) begin bad++; $display("FAIL ovr_frames got=%0d want=%0d", got_valid, exp_frames); end
    total++; if (bad_val !== 0 || got_ferr !== 0)
      begin bad++; $display("FAIL ovr_samples wrong=%0d ferr=%0d want 0/0", bad_val, got_ferr); end
    total++; if (consec2 !== 0) begin bad++; $display("FAIL ovr_valid_consec got=%0d want=0", consec2); end
  endtask

  task automatic test_invariants();
    total++; if (consec_valid !== 0) begin bad++; $display("FAIL valid_consecutive got=%0d want=0", consec_valid); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_reset_mid_frame();
    test_enable_drop();
    test_overrun();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
